// File: rtl/jk_pkg.sv
// Shared types for the JK excitation driver.
// State encoding and the {J,K} excitation codes.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK
    } state_t;

    localparam logic [1:0] HOLD   = 2'b00;
    localparam logic [1:0] SET    = 2'b10;
    localparam logic [1:0] RESET  = 2'b01;
    localparam logic [1:0] TOGGLE = 2'b11;

endpackage

// File: rtl/jk_excite_bit.sv
// One lane of JK excitation logic.
// Maps current Q and target bit to a {J,K} pair.
module jk_excite_bit
    import jk_pkg::*;
(
    input  logic q,
    input  logic t,
    input  logic use_toggle,
    output logic j,
    output logic k
);

    logic [1:0] code;

    // Pick hold, set, reset or toggle for this lane
    always_comb begin
        code = HOLD;
        unique case (1'b1)
            (q == t):                   code = HOLD;
            (q != t) && use_toggle:     code = TOGGLE;
            !q && t && !use_toggle:     code = SET;
            q && !t && !use_toggle:     code = RESET;
            default:                    code = HOLD;
        endcase
    end

    assign {j, k} = code;

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives an external JK bank toward a target word.
// One DRIVE cycle, one CHECK cycle, bounded retries.
module jk_excitation_driver
    import jk_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int USE_TOGGLE = 0,
    parameter int MAX_RETRY  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [WIDTH-1:0]                tgt_data,
    input  logic                            tgt_valid,
    output logic                            tgt_ready,
    input  logic [WIDTH-1:0]                q_fb,
    output logic [WIDTH-1:0]                j_out,
    output logic [WIDTH-1:0]                k_out,
    output logic                            done,
    output logic                            err,
    output logic                            match,
    output logic [$clog2(MAX_RETRY+2)-1:0]  attempts
);

    localparam int AW = $clog2(MAX_RETRY + 2);

    state_t           state;
    logic [WIDTH-1:0] tgt_q;
    logic [WIDTH-1:0] lane_t;
    logic [WIDTH-1:0] exc_j;
    logic [WIDTH-1:0] exc_k;

    assign tgt_ready = (state == IDLE) && !rst;

    // Excite toward the incoming word when idle, else the captured one
    assign lane_t = (state == IDLE) ? tgt_data : tgt_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        jk_excite_bit u_bit (
            .q          (q_fb[i]),
            .t          (lane_t[i]),
            .use_toggle (USE_TOGGLE != 0),
            .j          (exc_j[i]),
            .k          (exc_k[i])
        );
    end

    // Transaction FSM with registered outputs and attempt counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tgt_q    <= '0;
            j_out    <= '0;
            k_out    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            match    <= 1'b0;
            attempts <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tgt_valid) begin
                        tgt_q    <= tgt_data;
                        attempts <= AW'(1);
                        match    <= 1'b0;
                        j_out    <= exc_j;
                        k_out    <= exc_k;
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    j_out <= '0;
                    k_out <= '0;
                    state <= CHECK;
                end
                CHECK: begin
                    if (q_fb == tgt_q) begin
                        done  <= 1'b1;
                        match <= 1'b1;
                        state <= IDLE;
                    end else if (attempts <= AW'(MAX_RETRY)) begin
                        attempts <= attempts + AW'(1);
                        j_out    <= exc_j;
                        k_out    <= exc_k;
                        state    <= DRIVE;
                    end else begin
                        err   <= 1'b1;
                        match <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Scoreboard bench: set/reset and toggle instances side by side.
// Each instance drives its own modelled JK bank.
module tb_jk_excitation_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] tgt_data = '0;
    logic       tgt_valid = 1'b0;

    logic       rdy0, rdy1;
    logic [3:0] j0, k0, j1, k1;
    logic       d0, e0, m0, d1, e1, m1;
    logic [1:0] a0, a1;

    logic [3:0] q0 = '0;
    logic [3:0] q1 = '0;
    logic       pre = 1'b0;
    logic       stuck = 1'b0;
    logic [3:0] pv0 = '0;
    logic [3:0] pv1 = '0;

    logic [7:0] drv_q [2][$];
    logic [4:0] res_q [2][$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jk_excitation_driver #(.WIDTH(4), .USE_TOGGLE(0), .MAX_RETRY(2)) u_sr (
        .clk(clk), .rst(rst), .tgt_data(tgt_data), .tgt_valid(tgt_valid),
        .tgt_ready(rdy0), .q_fb(q0), .j_out(j0), .k_out(k0),
        .done(d0), .err(e0), .match(m0), .attempts(a0)
    );

    jk_excitation_driver #(.WIDTH(4), .USE_TOGGLE(1), .MAX_RETRY(2)) u_tg (
        .clk(clk), .rst(rst), .tgt_data(tgt_data), .tgt_valid(tgt_valid),
        .tgt_ready(rdy1), .q_fb(q1), .j_out(j1), .k_out(k1),
        .done(d1), .err(e1), .match(m1), .attempts(a1)
    );

    // External JK bank model: Q+ = J&~Q | ~K&Q
    always @(posedge clk) begin
        if (pre) begin
            q0 <= pv0;
            q1 <= pv1;
        end else if (!stuck) begin
            q0 <= (j0 & ~q0) | (~k0 & q0);
            q1 <= (j1 & ~q1) | (~k1 & q1);
        end
    end

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon(input int id, input logic [3:0] j, input logic [3:0] k,
                       input logic d, input logic e, input logic m,
                       input logic [1:0] a);
        logic [7:0] ed;
        logic [4:0] er;
        if ((j | k) != 4'b0) begin
            if (drv_q[id].size() == 0) begin
                chk($sformatf("drv%0d_unexpected", id), {j, k}, 8'h00);
            end else begin
                ed = drv_q[id].pop_front();
                chk($sformatf("drv%0d_jk", id), {j, k}, ed);
            end
        end
        if (d || e) begin
            chk($sformatf("excl%0d", id), {7'b0, d & e}, 8'h00);
            if (res_q[id].size() == 0) begin
                chk($sformatf("res%0d_unexpected", id), {3'b0, d, e, m, a}, 8'h00);
            end else begin
                er = res_q[id].pop_front();
                chk($sformatf("res%0d", id), {3'b0, d, e, m, a}, {3'b0, er});
            end
        end
    endtask

    // Monitor: compare every drive pattern and every result pulse
    always @(negedge clk) begin
        if (!rst) begin
            mon(0, j0, k0, d0, e0, m0, a0);
            mon(1, j1, k1, d1, e1, m1, a1);
        end
    end

    task automatic exp_drv(input logic [3:0] sj, input logic [3:0] sk,
                           input logic [3:0] tj, input logic [3:0] tk);
        drv_q[0].push_back({sj, sk});
        drv_q[1].push_back({tj, tk});
    endtask

    task automatic exp_res(input logic ok, input logic [1:0] a);
        res_q[0].push_back({ok, !ok, ok, a});
        res_q[1].push_back({ok, !ok, ok, a});
    endtask

    task automatic preset(input logic [3:0] v0, input logic [3:0] v1);
        @(posedge clk);
        #1;
        pv0 = v0;
        pv1 = v1;
        pre = 1'b1;
        @(posedge clk);
        #1;
        pre = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!rdy0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy0) chk("ready_timeout", 8'h00, 8'h01);
    endtask

    task automatic send(input logic [3:0] t);
        int n;
        tgt_data  = t;
        tgt_valid = 1'b1;
        wait_ready(n);
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
        chk("busy_ready", {6'b0, rdy0, rdy1}, 8'h00);
        @(posedge clk);
        #1;
        chk("check_zero0", {j0, k0}, 8'h00);
        chk("check_zero1", {j1, k1}, 8'h00);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((res_q[0].size() != 0 || res_q[1].size() != 0 ||
                drv_q[0].size() != 0 || drv_q[1].size() != 0) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 40) chk("idle_timeout", 8'h00, 8'h01);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        // Reset state
        #2;
        chk("rst_ready", {6'b0, rdy0, rdy1}, 8'h00);
        chk("rst_out0", {j0, k0}, 8'h00);
        chk("rst_flags0", {3'b0, d0, e0, m0, a0}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rel_ready", {6'b0, rdy0, rdy1}, 8'h03);
        chk("rel_attempts", {4'b0, a0, a1}, 8'h00);

        // Reset in the middle of DRIVE
        preset(4'b0000, 4'b0000);
        tgt_data  = 4'b1010;
        tgt_valid = 1'b1;
        wait_ready(n);
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
        chk("mid_j0", {j0, k0}, 8'b1010_0000);
        chk("mid_j1", {j1, k1}, 8'b1010_1010);
        rst = 1'b1;
        #1;
        chk("mid_rst_jk", {j0, k0, j1, k1} == 16'h0 ? 8'h00 : 8'h01, 8'h00);
        chk("mid_rst_flags", {d0, e0, m0, d1, e1, m1, rdy0, rdy1}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rel", {2'b0, rdy0, rdy1, a0, a1}, 8'b0011_0000);

        // Set from zero, with latency check
        preset(4'b0000, 4'b0000);
        exp_drv(4'b1010, 4'b0000, 4'b1010, 4'b1010);
        exp_res(1'b1, 2'd1);
        send(4'b1010);
        @(posedge clk);
        #1;
        chk("latency_done", {6'b0, d0, d1}, 8'h03);
        wait_idle();

        // Clear all ones
        preset(4'b1111, 4'b1111);
        exp_drv(4'b0000, 4'b1111, 4'b1111, 4'b1111);
        exp_res(1'b1, 2'd1);
        send(4'b0000);
        wait_idle();

        // Mixed: 1100 -> 0110
        preset(4'b1100, 4'b1100);
        exp_drv(4'b0010, 4'b1000, 4'b1010, 4'b1010);
        exp_res(1'b1, 2'd1);
        send(4'b0110);
        wait_idle();

        // Target equal to Q: zero drive, still done
        preset(4'b0101, 4'b0101);
        exp_res(1'b1, 2'd1);
        send(4'b0101);
        wait_idle();

        // Stuck bank: three attempts then err
        preset(4'b0000, 4'b0000);
        stuck = 1'b1;
        for (int i = 0; i < 3; i++) exp_drv(4'b0001, 4'b0000, 4'b0001, 4'b0001);
        exp_res(1'b0, 2'd3);
        send(4'b0001);
        wait_idle();
        stuck = 1'b0;
        chk("err_match", {6'b0, m0, m1}, 8'h00);

        // Valid held high across two words; data changes while busy
        preset(4'b0000, 4'b0000);
        exp_drv(4'b0011, 4'b0000, 4'b0011, 4'b0011);
        exp_drv(4'b0100, 4'b0010, 4'b0110, 4'b0110);
        exp_res(1'b1, 2'd1);
        exp_res(1'b1, 2'd1);
        tgt_data  = 4'b0011;
        tgt_valid = 1'b1;
        wait_ready(n);
        @(posedge clk);
        #1;
        tgt_data = 4'b0101;
        wait_ready(n);
        chk("hs_gap", 8'(n), 8'd2);
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
        wait_idle();
        chk("hs_final_q", {q0, q1}, 8'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
